// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM: sequences the shared MIPS datapath one state per clock.
// Optional macro MC_CTRL_LOGIC_IMM_EN enables ANDI/ORI with zero-extended immediates.
module mc_main_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       sign,
   output logic       illegal,
   output logic [3:0] state
);

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 4;

   localparam logic [OP_W-1:0] OP_R    = 6'h00;
   localparam logic [OP_W-1:0] OP_J    = 6'h02;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE  = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
   localparam logic [OP_W-1:0] OP_LW   = 6'h23;
   localparam logic [OP_W-1:0] OP_SW   = 6'h2B;
`ifdef MC_CTRL_LOGIC_IMM_EN
   localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
`endif

   typedef enum logic [STATE_W-1:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_IMMEXEC = 4'd10,
      S_IMMWB   = 4'd11,
      S_JUMP    = 4'd12
   } state_t;

   state_t cur_state;
   state_t nxt_state;

   // Opcode class decode from the instruction register
   logic op_r, op_j, op_beq, op_bne, op_addi, op_lw, op_sw;
   logic op_mem, op_br, op_imm, op_legal;

   assign op_r    = (opcode == OP_R);
   assign op_j    = (opcode == OP_J);
   assign op_beq  = (opcode == OP_BEQ);
   assign op_bne  = (opcode == OP_BNE);
   assign op_addi = (opcode == OP_ADDI);
   assign op_lw   = (opcode == OP_LW);
   assign op_sw   = (opcode == OP_SW);
   assign op_mem  = op_lw | op_sw;
   assign op_br   = op_beq | op_bne;

`ifdef MC_CTRL_LOGIC_IMM_EN
   logic op_logic;
   assign op_logic = (opcode == OP_ANDI) | (opcode == OP_ORI);
   assign op_imm   = op_addi | op_logic;
`else
   assign op_imm   = op_addi;
`endif

   assign op_legal = op_mem | op_r | op_br | op_imm | op_j;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= S_IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state logic; unused codes fall back to IDLE
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_IDLE:    if (run) nxt_state = S_FETCH;
         S_FETCH:   if (mem_ready) nxt_state = S_DECODE;
         S_DECODE: begin
            if (op_mem)      nxt_state = S_MEMADR;
            else if (op_r)   nxt_state = S_EXEC;
            else if (op_br)  nxt_state = S_BRANCH;
            else if (op_imm) nxt_state = S_IMMEXEC;
            else if (op_j)   nxt_state = S_JUMP;
            else             nxt_state = S_IDLE;
         end
         S_MEMADR: begin
            if (op_lw)       nxt_state = S_MEMRD;
            else if (op_sw)  nxt_state = S_MEMWR;
            else             nxt_state = S_IDLE;
         end
         S_MEMRD:   if (mem_ready) nxt_state = S_MEMWB;
         S_MEMWR:   if (mem_ready) nxt_state = S_FETCH;
         S_EXEC:    nxt_state = S_ALUWB;
         S_IMMEXEC: nxt_state = S_IMMWB;
         S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP:
            nxt_state = run ? S_FETCH : S_IDLE;
         default:   nxt_state = S_IDLE;
      endcase
   end

   // Moore strobes from the registered state; only handshakes/flags gate them
   always_comb begin
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      pc_en      = 1'b0;
      sign       = 1'b1;
      illegal    = 1'b0;
      case (cur_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            illegal   = ~op_legal;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            pc_en     = (op_beq & zero) | (op_bne & ~zero);
         end
         S_IMMEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
`ifdef MC_CTRL_LOGIC_IMM_EN
            alu_op    = op_logic ? 2'b11 : 2'b00;
            sign      = ~op_logic;
`endif
         end
         S_IMMWB: begin
            reg_write = 1'b1;
`ifdef MC_CTRL_LOGIC_IMM_EN
            alu_op    = op_logic ? 2'b11 : 2'b00;
            sign      = ~op_logic;
`endif
         end
         S_JUMP: begin
            pc_src = 2'b10;
            pc_en  = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = STATE_W'(cur_state);

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: directed scenarios plus randomized
// instruction streams checked against an instruction-level state-path model.
module tb_mc_main_ctrl;

   logic       clk = 1'b0;
   logic       rst, run, zero, mem_ready;
   logic [5:0] opcode;
   logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, pc_en, sign, illegal;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state;
   logic [15:0] strobes;

   int checks   = 0;
   int failures = 0;
   int exp_path[$];

`ifdef MC_CTRL_LOGIC_IMM_EN
   localparam bit LOGIC_EN = 1'b1;
`else
   localparam bit LOGIC_EN = 1'b0;
`endif

   mc_main_ctrl dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
      .sign(sign), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   assign strobes = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal};

   // Inputs change just after the falling edge; outputs are sampled 1ns later
   task automatic drive(input logic r, input logic [5:0] op, input logic mr, input logic z);
      run = r; opcode = op; mem_ready = mr; zero = z;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_instr(input logic [5:0] op);
      drive(1'b1, op, 1'b1, 1'b0);
      tick();
   endtask

   // Expected state path per opcode, straight from the instruction table
   task automatic build_path(input logic [5:0] op);
      exp_path = {1, 2};
      case (op)
         6'h23: exp_path = {1, 2, 3, 4, 5};
         6'h2B: exp_path = {1, 2, 3, 6};
         6'h00: exp_path = {1, 2, 7, 8};
         6'h04, 6'h05: exp_path = {1, 2, 9};
         6'h02: exp_path = {1, 2, 12};
         6'h08: exp_path = {1, 2, 10, 11};
         6'h0C, 6'h0D: if (LOGIC_EN) exp_path = {1, 2, 10, 11};
         default: ;
      endcase
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0; opcode = 6'h00; mem_ready = 1'b0; zero = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++;
      if (strobes !== 16'h0) begin failures++; $display("FAIL reset_strobes got=%h exp=0000", strobes); end
      checks++;
      if (sign !== 1'b1) begin failures++; $display("FAIL reset_sign got=%b exp=1", sign); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_lw();
      int exp_s[5] = '{1, 2, 3, 4, 5};
      start_instr(6'h23);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 6'h23, 1'b1, 1'b0);
         checks++;
         if (state !== 4'(exp_s[i])) begin failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
         checks++;
         if ({reg_write, mem_to_reg} !== ((exp_s[i] == 5) ? 2'b11 : 2'b00)) begin
            failures++; $display("FAIL lw_wb_strobes[%0d] got=%b%b", i, reg_write, mem_to_reg);
         end
         if (exp_s[i] == 3) begin
            checks++;
            if (sign !== 1'b1) begin failures++; $display("FAIL lw_memadr_sign got=%b exp=1", sign); end
         end
         tick();
      end
      drive(1'b0, 6'h23, 1'b1, 1'b0);
      checks++;
      if (state !== 4'd0) begin failures++; $display("FAIL lw_park got=%0d exp=0", state); end
   endtask

   task automatic test_ori();
      start_instr(6'h0D);
`ifdef MC_CTRL_LOGIC_IMM_EN
      begin
         int exp_s[4] = '{1, 2, 10, 11};
         for (int i = 0; i < 4; i++) begin
            drive(1'b0, 6'h0D, 1'b1, 1'b0);
            checks++;
            if (state !== 4'(exp_s[i])) begin failures++; $display("FAIL ori_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
            if (exp_s[i] >= 10) begin
               checks++;
               if ({sign, alu_op} !== 3'b011) begin
                  failures++; $display("FAIL ori_sign_aluop[%0d] got=%b/%b exp=0/11", i, sign, alu_op);
               end
            end
            tick();
         end
      end
`else
      drive(1'b0, 6'h0D, 1'b1, 1'b0);
      tick();
      drive(1'b0, 6'h0D, 1'b1, 1'b0);
      checks++;
      if ({state, illegal} !== {4'd2, 1'b1}) begin
         failures++; $display("FAIL ori_illegal got=state %0d illegal %b exp=state 2 illegal 1", state, illegal);
      end
      tick();
`endif
      drive(1'b0, 6'h0D, 1'b1, 1'b0);
      checks++;
      if ({state, illegal} !== {4'd0, 1'b0}) begin
         failures++; $display("FAIL ori_end got=state %0d illegal %b exp=state 0 illegal 0", state, illegal);
      end
   endtask

   task automatic test_branch();
      logic [5:0] ops[2] = '{6'h04, 6'h05};
      for (int k = 0; k < 2; k++) begin
         start_instr(ops[k]);
         repeat (2) begin drive(1'b0, ops[k], 1'b1, 1'b1); tick(); end
         drive(1'b0, ops[k], 1'b1, 1'b1);
         checks++;
         if (state !== 4'd9) begin failures++; $display("FAIL branch_state op=%h got=%0d exp=9", ops[k], state); end
         checks++;
         if ({pc_en, pc_src} !== ((k == 0) ? 3'b101 : 3'b001)) begin
            failures++; $display("FAIL branch_pc op=%h got pc_en=%b pc_src=%b", ops[k], pc_en, pc_src);
         end
         tick();
      end
   endtask

   task automatic test_fetch_stall();
      start_instr(6'h00);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 6'h00, 1'b0, 1'b0);
         checks++;
         if ({state, ir_write, pc_en} !== {4'd1, 2'b00}) begin
            failures++; $display("FAIL stall_fetch[%0d] got state=%0d ir_write=%b pc_en=%b exp 1/0/0", i, state, ir_write, pc_en);
         end
         tick();
      end
      drive(1'b0, 6'h00, 1'b1, 1'b0);
      checks++;
      if ({state, ir_write, pc_en} !== {4'd1, 2'b11}) begin
         failures++; $display("FAIL stall_release got state=%0d ir_write=%b pc_en=%b exp 1/1/1", state, ir_write, pc_en);
      end
      tick();
      drive(1'b0, 6'h00, 1'b1, 1'b0);
      checks++;
      if ({state, ir_write} !== {4'd2, 1'b0}) begin
         failures++; $display("FAIL stall_decode got state=%0d ir_write=%b exp 2/0", state, ir_write);
      end
      repeat (3) begin tick(); drive(1'b0, 6'h00, 1'b1, 1'b0); end
      checks++;
      if (state !== 4'd0) begin failures++; $display("FAIL stall_park got=%0d exp=0", state); end
   endtask

   task automatic test_illegal_op();
      start_instr(6'h3F);
      drive(1'b0, 6'h3F, 1'b1, 1'b0);
      checks++;
      if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_in_fetch got=%b exp=0", illegal); end
      tick();
      drive(1'b0, 6'h3F, 1'b1, 1'b0);
      checks++;
      if ({state, illegal} !== {4'd2, 1'b1}) begin
         failures++; $display("FAIL illegal_decode got state=%0d illegal=%b exp 2/1", state, illegal);
      end
      tick();
      drive(1'b0, 6'h3F, 1'b1, 1'b0);
      checks++;
      if ({state, strobes, sign} !== {4'd0, 16'h0, 1'b1}) begin
         failures++; $display("FAIL illegal_after got state=%0d strobes=%h sign=%b exp 0/0000/1", state, strobes, sign);
      end
   endtask

   task automatic test_reset_mid_memwr();
      start_instr(6'h2B);
      repeat (3) begin drive(1'b0, 6'h2B, 1'b1, 1'b0); tick(); end
      drive(1'b0, 6'h2B, 1'b0, 1'b0);
      checks++;
      if ({state, mem_write} !== {4'd6, 1'b1}) begin
         failures++; $display("FAIL memwr_before_rst got state=%0d mem_write=%b exp 6/1", state, mem_write);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({state, mem_write} !== {4'd0, 1'b0}) begin
         failures++; $display("FAIL async_rst got state=%0d mem_write=%b exp 0/0", state, mem_write);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 6'h00, 1'b1, 1'b0);
      checks++;
      if (state !== 4'd0) begin failures++; $display("FAIL rst_edge1 got=%0d exp=0", state); end
      @(posedge clk);
      #1;
      checks++;
      if (state !== 4'd1) begin failures++; $display("FAIL rst_edge2_fetch got=%0d exp=1", state); end
      @(negedge clk);
      run = 1'b0;
      repeat (4) tick();
      #1;
      checks++;
      if (state !== 4'd0) begin failures++; $display("FAIL rst_resume_park got=%0d exp=0", state); end
   endtask

   // Random opcodes, run, zero and memory stalls against the path model
   task automatic test_random();
      logic [5:0] pool[11] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C,
                               6'h0D, 6'h23, 6'h2B, 6'h3F, 6'h00};
      bit at_fetch = 1'b0;
      for (int n = 0; n < 80; n++) begin
         logic [5:0] op;
         int idx, cyc, pc_cnt, ir_cnt, rw_cnt, mw_cnt, ill_cnt, memwr_cycles;
         bit taken, legal, writes;
         op = pool[$urandom_range(0, 10)];
         if (n % 11 == 10) op = 6'($urandom);
         build_path(op);
         legal  = (exp_path.size() > 2);
         writes = (exp_path[exp_path.size()-1] == 5) || (exp_path[exp_path.size()-1] == 8) ||
                  (exp_path[exp_path.size()-1] == 11);
         if (!at_fetch) begin
            drive(1'b1, op, 1'($urandom), 1'($urandom));
            checks++;
            if (state !== 4'd0) begin failures++; $display("FAIL rnd_idle n=%0d got=%0d exp=0", n, state); end
            tick();
         end
         idx = 0; cyc = 0; pc_cnt = 0; ir_cnt = 0; rw_cnt = 0; mw_cnt = 0; ill_cnt = 0;
         memwr_cycles = 0; taken = 1'b0; at_fetch = 1'b0;
         while (idx < exp_path.size() && cyc < 60) begin
            int  st;
            bit  r, mr, z, exp_sign;
            st = exp_path[idx];
            r  = 1'($urandom);
            mr = ($urandom_range(0, 3) != 0);
            z  = 1'($urandom);
            drive(r, op, mr, z);
            exp_sign = !(LOGIC_EN && (op == 6'h0C || op == 6'h0D) && (st == 10 || st == 11));
            checks++;
            if (state !== 4'(st)) begin
               failures++; $display("FAIL rnd_state n=%0d op=%h step=%0d got=%0d exp=%0d", n, op, idx, state, st);
            end
            checks++;
            if (sign !== exp_sign) begin
               failures++; $display("FAIL rnd_sign n=%0d op=%h state=%0d got=%b exp=%b", n, op, st, sign, exp_sign);
            end
            pc_cnt  += int'(pc_en);
            ir_cnt  += int'(ir_write);
            rw_cnt  += int'(reg_write);
            mw_cnt  += int'(mem_write);
            ill_cnt += int'(illegal);
            if (st == 6) memwr_cycles++;
            if (st == 9) taken = (op == 6'h04) ? z : !z;
            if (!(st == 1 || st == 4 || st == 6) || mr) begin
               if (idx == exp_path.size() - 1) at_fetch = (st == 6) || (r && st != 2);
               idx++;
            end
            tick();
            cyc++;
         end
         checks++;
         if (cyc >= 60) begin failures++; $display("FAIL rnd_timeout n=%0d op=%h", n, op); end
         checks++;
         if (pc_cnt != 1 + int'(taken) + int'(op == 6'h02)) begin
            failures++; $display("FAIL rnd_pc_en n=%0d op=%h got=%0d exp=%0d", n, op, pc_cnt, 1 + int'(taken) + int'(op == 6'h02));
         end
         checks++;
         if (ir_cnt != 1) begin failures++; $display("FAIL rnd_ir_write n=%0d got=%0d exp=1", n, ir_cnt); end
         checks++;
         if (rw_cnt != int'(writes)) begin failures++; $display("FAIL rnd_reg_write n=%0d op=%h got=%0d exp=%0d", n, op, rw_cnt, int'(writes)); end
         checks++;
         if (mw_cnt != memwr_cycles) begin failures++; $display("FAIL rnd_mem_write n=%0d got=%0d exp=%0d", n, mw_cnt, memwr_cycles); end
         checks++;
         if (ill_cnt != int'(!legal)) begin failures++; $display("FAIL rnd_illegal n=%0d op=%h got=%0d exp=%0d", n, op, ill_cnt, int'(!legal)); end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      tick();
      test_ori();
      tick();
      test_branch();
      test_fetch_stall();
      tick();
      test_illegal_op();
      tick();
      test_reset_mid_memwr();
      tick();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Multi-cycle main control FSM for the MIPS core. It sequences the shared datapath (PC, memory port, instruction register, register file, ALU, sign-extension unit) one state per clock. It decodes the latched opcode into per-state strobes and mux selects, including the `sign` select that chooses sign- or zero-extension of the 16-bit immediate. It sits between the instruction register and the datapath; the ALU decoder consumes its `alu_op`.

## Interface
Parameters:
- none (opcode values fixed: R=6'h00, J=6'h02, BEQ=6'h04, BNE=6'h05, ADDI=6'h08, ANDI=6'h0C, ORI=6'h0D, LW=6'h23, SW=6'h2B)

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: start/continue execution; sampled in IDLE.
- `opcode` in 6: instr[31:26] from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory handshake; access completes in the cycle it is high.
- `iord`, `mem_read`, `mem_write`, `ir_write` out 1 each: memory address select (0=PC, 1=ALUOut), read, write, IR load.
- `reg_dst`, `mem_to_reg`, `reg_write` out 1 each: register-file controls.
- `alu_src_a` out 1; `alu_src_b` out 2; `alu_op` out 2; `pc_src` out 2.
- `pc_en` out 1: PC load = pc_write | (branch taken).
- `sign` out 1: 1 = sign-extend immediate, 0 = zero-extend.
- `illegal` out 1: one-cycle pulse on undecodable opcode.
- `state` out 4: current state, for debug.

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, IMMEXEC 10, IMMWB 11, JUMP 12. Codes 13-15 are unreachable and recover to IDLE.
- Transitions:
  - IDLE→FETCH when run=1.
  - FETCH→DECODE when mem_ready=1, else hold.
  - DECODE: LW/SW→MEMADR; R→EXEC; BEQ/BNE→BRANCH; ADDI/ANDI/ORI→IMMEXEC; J→JUMP; any other opcode→IDLE with illegal=1.
  - MEMADR: LW→MEMRD, SW→MEMWR.
  - MEMRD→MEMWB when mem_ready=1. MEMWR→FETCH when mem_ready=1.
  - EXEC→ALUWB. IMMEXEC→IMMWB.
  - MEMWB, ALUWB, IMMWB, BRANCH, JUMP→FETCH if run=1, else →IDLE.
- Outputs are Moore, decoded from the registered state and the IR opcode. Strobes not listed for a state are 0.
  - FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_en = mem_ready.
  - DECODE: alu_src_b=11, alu_op=00, sign=1 (branch target precompute).
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00, sign=1.
  - MEMRD: iord=1, mem_read=1. MEMWB: reg_write=1, mem_to_reg=1.
  - MEMWR: iord=1, mem_write=1 (held until mem_ready).
  - EXEC: alu_src_a=1, alu_op=10. ALUWB: reg_dst=1, reg_write=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_src=01, sign=1. pc_en = zero for BEQ, ~zero for BNE.
  - IMMEXEC: alu_src_a=1, alu_src_b=10. ADDI: alu_op=00, sign=1. ANDI/ORI: alu_op=11, sign=0.
  - IMMWB: reg_write=1; sign and alu_op held as in IMMEXEC.
  - JUMP: pc_src=10, pc_en=1.
  - IDLE: all strobes 0.
- Default sign=1 in every state not listed above.

## Timing
- Reset: state=IDLE. All outputs 0 except sign=1, state=0.
- Reset mid-instruction returns to IDLE immediately (asynchronous). Any in-flight mem_write drops the same instant.
- Instruction latency with mem_ready tied high, counting from FETCH:
  - R, ADDI, ANDI, ORI: 4 cycles.
  - LW: 5 cycles. SW: 4 cycles.
  - BEQ, BNE, J: 3 cycles.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle; state and outputs are held.
- mem_ready is ignored in all other states.
- run=0 during an instruction does not abort it; the FSM finishes the instruction then parks in IDLE.
- illegal is asserted during the DECODE cycle only.

## Configuration
- `MC_CTRL_LOGIC_IMM_EN`
  - Defined: ANDI/ORI decode as above, with zero-extension (sign=0).
  - Undefined: ANDI/ORI are illegal (DECODE→IDLE, illegal=1), and sign is constant 1.

## Test plan
- Reset with rst=1 mid-MEMWR → state=0 and mem_write=0 within the same cycle; after release with run=1, FETCH occurs on the 2nd edge.
- LW (opcode 23h), mem_ready high → states 1,2,3,4,5 in order; reg_write=1 and mem_to_reg=1 only in state 5; sign=1 in state 3.
- ORI (0Dh) → states 1,2,10,11; sign=0 and alu_op=11 in states 10-11. Without the macro: illegal pulses and state returns to 0.
- BEQ with zero=1 → pc_en=1, pc_src=01 in state 9. BNE with zero=1 → pc_en=0 in state 9.
- FETCH with mem_ready low for 3 cycles → state stays 1 for 4 cycles; ir_write=0 until the mem_ready cycle, then ir_write=1 and pc_en=1 for one cycle.
- Opcode 3Fh → illegal=1 for one cycle in state 2, then state 0 with all strobes 0.
